// File: rtl/wb_sram_target.sv
// Wishbone classic-cycle target that terminates one interconnect port with a local SRAM.
// Each request is registered, held for WAIT_STATES cycles, then answered by a one-cycle ACK or ERR.
module wb_sram_target #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       DEPTH         = 1024,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADR      = 32'h2800_0000,
    parameter int                       WAIT_STATES   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       WE,
    output logic                       ACK,
    output logic                       ERR,
    output logic [1:0]                 dbg_state
);

    localparam int LANES      = WB_DATA_WIDTH / 8;
    localparam int LANE_SHIFT = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int OFF_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: CYC&STB is the request; it is accepted only in S_IDLE, and the
    // access completes with exactly one cycle of ACK (in range) or ERR (out of range).
    state_t                   state, state_next;
    logic [3:0]               wait_cnt;
    logic [WB_ADDR_WIDTH-1:0] rel_adr;
    logic [WB_ADDR_WIDTH-1:0] cur_off_full;
    logic                     cur_in_range;
    logic [OFF_W-1:0]         cur_off;
    logic                     take;

    logic [OFF_W-1:0]         req_off;
    logic                     req_in_range;
    logic                     req_we;
    logic [WB_DATA_WIDTH-1:0] req_dat;
    logic [LANES-1:0]         req_sel;

    logic [OFF_W-1:0]         rd_off;
    logic                     rd_in_range;
    logic [WB_DATA_WIDTH-1:0] rd_data;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    // Addresses below the base wrap to a huge offset and decode as out of range.
    assign rel_adr      = ADR - BASE_ADR;
    assign cur_off_full = rel_adr >> LANE_SHIFT;
    assign cur_in_range = cur_off_full < WB_ADDR_WIDTH'(DEPTH);
    assign cur_off      = cur_off_full[OFF_W-1:0];
    assign take         = (state == S_IDLE) && CYC && STB;

    // With no wait states the read launches from the live address in the capture cycle.
    assign rd_off      = (state == S_IDLE) ? cur_off : req_off;
    assign rd_in_range = (state == S_IDLE) ? cur_in_range : req_in_range;

    always_comb begin
        state_next = state;
        ACK        = 1'b0;
        ERR        = 1'b0;
        case (state)
            S_IDLE: begin
                if (CYC && STB) begin
                    state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!CYC) begin
                    state_next = S_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                ACK        = req_in_range;
                ERR        = !req_in_range;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            rd_data      <= '0;
            req_off      <= '0;
            req_in_range <= 1'b0;
            req_we       <= 1'b0;
            req_dat      <= '0;
            req_sel      <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                req_off      <= cur_off;
                req_in_range <= cur_in_range;
                req_we       <= WE;
                req_dat      <= DAT_W;
                req_sel      <= SEL;
                wait_cnt     <= 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state_next == S_RESP && rd_in_range) begin
                rd_data <= mem[rd_off];
            end else begin
                rd_data <= '0;
            end
        end
    end

    // The array is not reset; writes land on the edge that leaves S_RESP.
    always_ff @(posedge clk) begin
        if (state == S_RESP && req_in_range && req_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (req_sel[b]) begin
                    mem[req_off][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

    assign DAT_R     = rd_data;
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_sram_target.sv
// Bench for wb_sram_target: three instances (WAIT_STATES 1, 0, 3) driven by tasks and
// checked against a byte-level memory model derived from the address-decode rules.
module tb_wb_sram_target;

    localparam logic [31:0] BASE = 32'h2800_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic [3:0]  sel   [3];
    logic        we    [3];
    logic        ack   [3];
    logic        err   [3];
    logic [1:0]  dbg   [3];

    int checks;
    int failures;

    logic [31:0] ref_mem   [3][1024];
    bit          ref_known [3][1024];
    logic [31:0] exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_sram_target #(
            .WB_ADDR_WIDTH(32),
            .WB_DATA_WIDTH(32),
            .DEPTH        (1024),
            .BASE_ADR     (32'h2800_0000),
            .WAIT_STATES  (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .ADR      (adr[g]),
            .DAT_W    (dat_w[g]),
            .DAT_R    (dat_r[g]),
            .CYC      (cyc[g]),
            .STB      (stb[g]),
            .SEL      (sel[g]),
            .WE       (we[g]),
            .ACK      (ack[g]),
            .ERR      (err[g]),
            .dbg_state(dbg[g])
        );
    end

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ACK and ERR must never be high together on any instance.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ack[i] || err[i]) begin
                    checks++;
                    if (ack[i] && err[i]) begin
                        failures++;
                        $display("FAIL ack_err_exclusive: inst %0d ack=%b err=%b, required not both", i, ack[i], err[i]);
                    end
                end
            end
        end
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    // Reference model: offset and range come straight from the byte-address rules.
    function automatic logic [31:0] off_of(input logic [31:0] a);
        return (a - BASE) >> 2;
    endfunction

    task automatic model_write(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        off = off_of(a);
        if (off < 32'd1024) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[i][off[9:0]][8*b +: 8] = d[8*b +: 8];
            end
            if (s == 4'hF) ref_known[i][off[9:0]] = 1'b1;
        end
    endtask

    // Driver: one complete classic cycle with a bounded wait for the termination.
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [1:0] got,
                        output logic [31:0] rd, output logic [1:0] exp_resp,
                        output logic [31:0] exp_rd, output bit known);
        logic [31:0] off;
        off      = off_of(a);
        exp_resp = (off < 32'd1024) ? 2'b10 : 2'b01;
        exp_rd   = '0;
        known    = !w;
        if (!w && off < 32'd1024) begin
            known  = ref_known[i][off[9:0]];
            exp_rd = ref_mem[i][off[9:0]];
        end
        @(posedge clk); #1;
        adr[i] = a; dat_w[i] = d; sel[i] = s; we[i] = w; cyc[i] = 1'b1; stb[i] = 1'b1;
        lat = 0; got = 2'b00; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack[i] || err[i]) begin
                lat = k; got = {ack[i], err[i]}; rd = dat_r[i];
                break;
            end
        end
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
        if (w) model_write(i, a, d, s);
    endtask

    task automatic sample_next(input int i, output logic [1:0] resp, output logic [31:0] rd);
        @(posedge clk); #1;
        resp = {ack[i], err[i]};
        rd   = dat_r[i];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ack[i], err[i]} !== 2'b00 || dat_r[i] !== 32'h0 || dbg[i] !== 2'd0) begin
                failures++;
                $display("FAIL reset_state: inst %0d ack=%b err=%b dat_r=%h state=%0d, required 0/0/0/0",
                         i, ack[i], err[i], dat_r[i], dbg[i]);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [1:0] got, er, pr; logic [31:0] rd, erd, prd; bit kn;
        xfer(0, 1'b1, 32'h2800_0004, 32'hDEAD_BEEF, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || lat != ws_of(0) + 1) begin
            failures++;
            $display("FAIL basic_write: resp=%b lat=%0d, required resp=%b lat=%0d", got, lat, er, ws_of(0) + 1);
        end
        sample_next(0, pr, prd);
        checks++;
        if (pr !== 2'b00) begin
            failures++;
            $display("FAIL basic_ack_pulse: resp next cycle=%b, required 00", pr);
        end
        xfer(0, 1'b0, 32'h2800_0004, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL basic_read: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
        sample_next(0, pr, prd);
        checks++;
        if (pr !== 2'b00 || prd !== 32'h0) begin
            failures++;
            $display("FAIL basic_read_after: resp=%b data=%h, required 00 and 00000000", pr, prd);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [1:0] got, er; logic [31:0] rd, erd; bit kn;
        xfer(0, 1'b1, 32'h2800_0008, 32'h1122_3344, 4'hF, lat, got, rd, er, erd, kn);
        xfer(0, 1'b1, 32'h2800_0008, 32'hAA55_AA55, 4'b0101, lat, got, rd, er, erd, kn);
        xfer(0, 1'b1, 32'h2800_0008, 32'hFFFF_FFFF, 4'b0000, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er) begin
            failures++;
            $display("FAIL sel0_write_resp: resp=%b, required %b", got, er);
        end
        xfer(0, 1'b0, 32'h2800_0008, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL byte_lanes: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
    endtask

    task automatic test_decode();
        int lat; logic [1:0] got, er; logic [31:0] rd, erd; bit kn;
        xfer(0, 1'b1, 32'h2800_0FFC, $urandom, 4'hF, lat, got, rd, er, erd, kn);
        xfer(0, 1'b0, 32'h2800_0FFC, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL decode_last_word: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
        xfer(0, 1'b0, 32'h2800_1000, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL decode_past_end: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
        xfer(0, 1'b1, 32'h27FF_FFFC, 32'h0BAD_0BAD, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er) begin
            failures++;
            $display("FAIL decode_below_base: resp=%b, required %b", got, er);
        end
        xfer(0, 1'b0, 32'h2800_0FFF, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL decode_err_no_write: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
    endtask

    task automatic test_latency();
        int lat; logic [1:0] got, er; logic [31:0] rd, erd; bit kn;
        for (int i = 1; i <= 2; i++) begin
            xfer(i, 1'b1, 32'h2800_0040, $urandom, 4'hF, lat, got, rd, er, erd, kn);
            checks++;
            if (got !== er || lat != ws_of(i) + 1) begin
                failures++;
                $display("FAIL latency: inst %0d resp=%b cycles=%0d, required resp=%b cycles=%0d",
                         i, got, lat, er, ws_of(i) + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 2; i++) begin
            logic [31:0] a, v, rd;
            int k1, gap;
            a = 32'h2800_0100 + 32'(i * 4);
            v = $urandom;
            @(posedge clk); #1;
            adr[i] = a; dat_w[i] = v; sel[i] = 4'hF; we[i] = 1'b1; cyc[i] = 1'b1; stb[i] = 1'b1;
            k1 = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (ack[i] || err[i]) begin k1 = k; break; end
            end
            we[i] = 1'b0;
            gap = 0; rd = '0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (ack[i] || err[i]) begin gap = k; rd = dat_r[i]; break; end
            end
            cyc[i] = 1'b0; stb[i] = 1'b0;
            model_write(i, a, v, 4'hF);
            checks++;
            if (k1 != ws_of(i) + 1 || gap != ws_of(i) + 2) begin
                failures++;
                $display("FAIL back_to_back_timing: inst %0d first=%0d gap=%0d, required first=%0d gap=%0d",
                         i, k1, gap, ws_of(i) + 1, ws_of(i) + 2);
            end
            checks++;
            if (rd !== ref_mem[i][off_of(a) % 1024]) begin
                failures++;
                $display("FAIL back_to_back_data: inst %0d data=%h, required %h", i, rd, ref_mem[i][off_of(a) % 1024]);
            end
        end
    endtask

    task automatic test_abort();
        int lat, seen; logic [1:0] got, er; logic [31:0] rd, erd; bit kn;
        xfer(2, 1'b1, 32'h2800_0010, $urandom, 4'hF, lat, got, rd, er, erd, kn);
        @(posedge clk); #1;
        adr[2] = 32'h2800_0010; dat_w[2] = 32'hCAFE_F00D; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_resp: responses=%0d, required 0", seen);
        end
        xfer(2, 1'b0, 32'h2800_0010, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL abort_no_write: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] got, er; logic [31:0] rd, erd; bit kn;
        xfer(2, 1'b1, 32'h2800_0020, $urandom, 4'hF, lat, got, rd, er, erd, kn);
        @(posedge clk); #1;
        adr[2] = 32'h2800_0020; dat_w[2] = ~ref_mem[2][8]; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack[2], err[2]} !== 2'b00 || dbg[2] !== 2'd0) begin
            failures++;
            $display("FAIL reset_in_wait: ack=%b err=%b state=%0d, required 0/0/0", ack[2], err[2], dbg[2]);
        end
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        xfer(2, 1'b0, 32'h2800_0020, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd) begin
            failures++;
            $display("FAIL reset_wait_no_write: resp=%b data=%h, required resp=%b data=%h", got, rd, er, erd);
        end

        xfer(0, 1'b1, 32'h2800_0030, $urandom, 4'hF, lat, got, rd, er, erd, kn);
        @(posedge clk); #1;
        adr[0] = 32'h2800_0030; dat_w[0] = ~ref_mem[0][12]; sel[0] = 4'hF; we[0] = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ack[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_resp_setup: ack=%b, required 1", ack[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack[0], err[0]} !== 2'b00 || dat_r[0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_resp: ack=%b err=%b data=%h, required 0/0/00000000", ack[0], err[0], dat_r[0]);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h2800_0030, 32'h0, 4'hF, lat, got, rd, er, erd, kn);
        checks++;
        if (got !== er || rd !== erd || lat != ws_of(0) + 1) begin
            failures++;
            $display("FAIL reset_resp_recovery: resp=%b data=%h lat=%0d, required resp=%b data=%h lat=%0d",
                     got, rd, lat, er, erd, ws_of(0) + 1);
        end
    endtask

    task automatic test_random();
        int lat; logic [1:0] got, er; logic [31:0] rd, erd, a, expd; bit kn;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 16; w++) begin
                xfer(i, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, lat, got, rd, er, erd, kn);
            end
            for (int n = 0; n < 30; n++) begin
                int r;
                logic wr;
                r = $urandom_range(0, 9);
                if (r < 7) a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                else if (r == 7) a = BASE + 32'($urandom_range(1020, 1027) * 4);
                else a = BASE - 32'($urandom_range(1, 4) * 4);
                wr = 1'($urandom_range(0, 1));
                xfer(i, wr, a, $urandom, 4'($urandom_range(0, 15)), lat, got, rd, er, erd, kn);
                checks++;
                if (got !== er || lat != ws_of(i) + 1) begin
                    failures++;
                    $display("FAIL random_resp: inst %0d adr=%h we=%b resp=%b lat=%0d, required resp=%b lat=%0d",
                             i, a, wr, got, lat, er, ws_of(i) + 1);
                end
                if (!wr && kn) begin
                    exp_q.push_back(erd);
                    expd = exp_q.pop_front();
                    checks++;
                    if (rd !== expd) begin
                        failures++;
                        $display("FAIL random_read: inst %0d adr=%h data=%h, required %h", i, a, rd, expd);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; dat_w[i] = '0; sel[i] = '0; we[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_byte_lanes();
        test_decode();
        test_latency();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
